block_ram_arbiter: RTL and testbench

//  Shares the single-port block_ram (16-bit address, 32-bit data, 4-bit byte write enable) between two requesters (0 = CPU data port, 1 = loader/DMA).

---
 rtl/block_ram_pkg.sv | 28 ++
 rtl/block_ram_arbiter_if.sv | 28 ++
 rtl/block_ram.sv | 28 ++
 rtl/block_ram_arbiter_rr_arb2.sv | 30 +++
 rtl/block_ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_block_ram_arbiter.sv | 256 +++++++++++++++++++++++++
 6 files changed

// File: rtl/block_ram_pkg.sv
// Shared widths, state encodings and request payload for the block_ram arbiter.
package block_ram_pkg;

    localparam int unsigned RAM_ADDR_W  = 16;
    localparam int unsigned RAM_DATA_W  = 32;
    localparam int unsigned RAM_BE_W    = 4;
    localparam int unsigned RAM_WIN_BIT = 15;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_RESP  = ST_RESP
    } state_t;

    // One requester's transaction as latched by the arbiter.
    typedef struct packed {
        logic [RAM_BE_W-1:0]   we;
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/block_ram_arbiter_if.sv
// Requester-side bus of the arbiter: two packed requesters plus shared response.
interface block_ram_arbiter_if
    import block_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned BE_W   = RAM_BE_W
);
    logic [1:0]          req;
    logic [2*BE_W-1:0]   we;
    logic [2*ADDR_W-1:0] addr;
    logic [2*DATA_W-1:0] wdata;
    logic [1:0]          gnt;
    logic [1:0]          ack;
    logic [DATA_W-1:0]   rdata;
    logic                err;
    logic                busy;

    modport master (
        output req, we, addr, wdata,
        input  gnt, ack, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, ack, rdata, err, busy
    );
endinterface

// File: rtl/block_ram.sv
// Single-port block RAM with byte write enables and one-cycle registered read.
module block_ram
    import block_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
) (
    input  logic                clk,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [RAM_BE_W-1:0] write_enable,
    output logic [DATA_W-1:0]   data_out
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane writes and read-before-write output register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(RAM_BE_W); i++) begin
            if (write_enable[i]) begin
                mem[address][8*i +: 8] <= data_in[8*i +: 8];
            end
        end
        data_out <= mem[address];
    end

endmodule

// File: rtl/block_ram_arbiter_rr_arb2.sv
// Two-way round-robin winner select with a last-winner pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic       winner_c
);
    logic ptr_q;

    // Lone requester wins; on a tie the requester other than the last winner wins.
    always_comb begin
        winner_c = 1'b0;
        case (req)
            2'b10:   winner_c = 1'b1;
            2'b11:   winner_c = ~ptr_q;
            default: winner_c = 1'b0;
        endcase
    end

    // Pointer starts at 1 so requester 0 takes the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b1;
        end else if (update) begin
            ptr_q <= winner_c;
        end
    end

endmodule

// File: rtl/block_ram_arbiter.sv
// Shares one block_ram port between the CPU data port (0) and the loader (1).
module block_ram_arbiter
    import block_ram_pkg::*;
#(
    parameter int unsigned ADDR_W       = RAM_ADDR_W,
    parameter int unsigned DATA_W       = RAM_DATA_W,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BASE_BIT     = RAM_WIN_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    block_ram_arbiter_if.slave    bus,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W-1:0]     ram_data_in,
    output logic [RAM_BE_W-1:0]   ram_write_enable,
    input  logic [DATA_W-1:0]     ram_data_out
);
    localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    ram_req_t           txn_q, txn_d;
    logic               win_q, win_d;
    ram_req_t           sel;
    logic               winner_c;
    logic               arb_en;

    logic [1:0]          gnt_d, ack_d;
    logic [DATA_W-1:0]   rdata_d;
    logic                err_d, busy_d;
    logic [ADDR_W-1:0]   ram_address_d;
    logic [DATA_W-1:0]   ram_data_in_d;
    logic [RAM_BE_W-1:0] ram_we_d;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.req),
        .update   (arb_en),
        .winner_c (winner_c)
    );

    // Steer the winning requester's fields onto one payload.
    always_comb begin
        sel.we    = winner_c ? bus.we[2*RAM_BE_W-1:RAM_BE_W]  : bus.we[RAM_BE_W-1:0];
        sel.addr  = winner_c ? bus.addr[2*ADDR_W-1:ADDR_W]    : bus.addr[ADDR_W-1:0];
        sel.wdata = winner_c ? bus.wdata[2*DATA_W-1:DATA_W]   : bus.wdata[DATA_W-1:0];
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        txn_d         = txn_q;
        win_d         = win_q;
        arb_en        = 1'b0;
        gnt_d         = 2'b00;
        ack_d         = 2'b00;
        rdata_d       = bus.rdata;
        err_d         = bus.err;
        ram_address_d = ram_address;
        ram_data_in_d = ram_data_in;
        ram_we_d      = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    arb_en        = 1'b1;
                    win_d         = winner_c;
                    txn_d         = sel;
                    gnt_d         = winner_c ? 2'b10 : 2'b01;
                    ram_address_d = sel.addr;
                    ram_data_in_d = sel.wdata;
                    ram_we_d      = sel.addr[BASE_BIT] ? sel.we : '0;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ram_address_d = txn_q.addr;
                ram_data_in_d = txn_q.wdata;
                if ((txn_q.we != '0) || !txn_q.addr[BASE_BIT]) begin
                    ack_d   = win_q ? 2'b10 : 2'b01;
                    err_d   = !txn_q.addr[BASE_BIT];
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                ram_address_d = txn_q.addr;
                if (cnt_q == '0) begin
                    ack_d   = win_q ? 2'b10 : 2'b01;
                    err_d   = 1'b0;
                    rdata_d = ram_data_out;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, latched transaction and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            txn_q            <= '0;
            win_q            <= 1'b0;
            bus.gnt          <= 2'b00;
            bus.ack          <= 2'b00;
            bus.rdata        <= '0;
            bus.err          <= 1'b0;
            bus.busy         <= 1'b0;
            ram_address      <= '0;
            ram_data_in      <= '0;
            ram_write_enable <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            txn_q            <= txn_d;
            win_q            <= win_d;
            bus.gnt          <= gnt_d;
            bus.ack          <= ack_d;
            bus.rdata        <= rdata_d;
            bus.err          <= err_d;
            bus.busy         <= busy_d;
            ram_address      <= ram_address_d;
            ram_data_in      <= ram_data_in_d;
            ram_write_enable <= ram_we_d;
        end
    end

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Scoreboard bench for block_ram_arbiter driving a real block_ram.
module tb_block_ram_arbiter;
    import block_ram_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    block_ram_arbiter_if bus ();

    logic [15:0] ram_address;
    logic [31:0] ram_data_in;
    logic [3:0]  ram_write_enable;
    logic [31:0] ram_data_out;

    block_ram_arbiter #(.READ_LATENCY(1)) dut (
        .clk              (clk),
        .reset            (rst),
        .bus              (bus),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_write_enable (ram_write_enable),
        .ram_data_out     (ram_data_out)
    );

    block_ram ram (
        .clk          (clk),
        .address      (ram_address),
        .data_in      (ram_data_in),
        .write_enable (ram_write_enable),
        .data_out     (ram_data_out)
    );

    typedef struct {
        logic [1:0]  onehot;
        logic [31:0] rdata;
        logic        err;
        int          t0;
        int          lat;
    } exp_t;

    exp_t gq[$];
    exp_t aq[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int we_cycles = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pop expectations whenever a grant or completion pulse shows up.
    always @(negedge clk) begin
        exp_t e;
        if (ram_write_enable != 4'h0) we_cycles++;
        if (bus.gnt != 2'b00) begin
            if (gq.size() == 0) begin
                chk("gnt_spurious", 64'(bus.gnt), 64'd0);
            end else begin
                e = gq.pop_front();
                chk("gnt", 64'(bus.gnt), 64'(e.onehot));
                if (e.t0 >= 0) chk("gnt_latency", 64'(cyc - e.t0), 64'd1);
            end
        end
        if (bus.ack != 2'b00) begin
            if (aq.size() == 0) begin
                chk("ack_spurious", 64'(bus.ack), 64'd0);
            end else begin
                e = aq.pop_front();
                chk("ack", 64'(bus.ack), 64'(e.onehot));
                chk("rdata", 64'(bus.rdata), 64'(e.rdata));
                chk("err", 64'(bus.err), 64'(e.err));
                if (e.t0 >= 0) chk("ack_latency", 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    task automatic clear_bus();
        bus.req   = 2'b00;
        bus.we    = 8'h00;
        bus.addr  = 32'h0;
        bus.wdata = 64'h0;
    endtask

    task automatic wait_idle();
        int budget = 0;
        @(negedge clk);
        while (bus.busy && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("idle_reached", 64'(bus.busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"},   64'(bus.gnt),          64'd0);
        chk({tag, "_ack"},   64'(bus.ack),          64'd0);
        chk({tag, "_rdata"}, 64'(bus.rdata),        64'd0);
        chk({tag, "_err"},   64'(bus.err),          64'd0);
        chk({tag, "_busy"},  64'(bus.busy),         64'd0);
        chk({tag, "_raddr"}, 64'(ram_address),      64'd0);
        chk({tag, "_rdin"},  64'(ram_data_in),      64'd0);
        chk({tag, "_rwe"},   64'(ram_write_enable), 64'd0);
    endtask

    task automatic drive(input int r, input logic [3:0] we4, input logic [15:0] a, input logic [31:0] d);
        bus.req[r]            = 1'b1;
        bus.we[4*r +: 4]      = we4;
        bus.addr[16*r +: 16]  = a;
        bus.wdata[32*r +: 32] = d;
    endtask

    task automatic wait_bit(input string tag, input int r, input bit on_ack);
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(on_ack ? bus.ack[r] : bus.gnt[r]) && budget < 20);
        chk(tag, 64'(on_ack ? bus.ack[r] : bus.gnt[r]), 64'd1);
    endtask

    // One complete transaction for requester r with its expected response.
    task automatic do_txn(input int r, input logic [3:0] we4, input logic [15:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        exp_t e;
        bit   wr_in_win;
        wait_idle();
        wr_in_win = a[15] && (we4 != 4'h0);
        drive(r, we4, a, d);
        we_cycles = 0;
        e.onehot = 2'(1 << r);
        e.rdata  = 32'h0;
        e.err    = 1'b0;
        e.t0     = cyc;
        e.lat    = 1;
        gq.push_back(e);
        e.rdata  = exp_rdata;
        e.err    = exp_err;
        e.lat    = exp_lat;
        aq.push_back(e);
        wait_bit("gnt_seen", r, 1'b0);
        chk("ram_we_at_gnt", 64'(ram_write_enable), 64'(wr_in_win ? we4 : 4'h0));
        clear_bus();
        wait_bit("ack_seen", r, 1'b1);
        chk("we_cycles", 64'(we_cycles), 64'(wr_in_win ? 1 : 0));
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs(tag);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n;
        int   budget;

        clear_bus();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Full-word write then read back.
        do_txn(0, 4'hF, 16'h8000, 32'hFFFF_FFFF, 32'h0, 1'b0, 2);
        do_txn(0, 4'h0, 16'h8000, 32'h0, 32'hFFFF_FFFF, 1'b0, 3);

        // Byte-lane writes from both requesters.
        do_txn(0, 4'hF,    16'h805B, 32'hFFFF_FFFF, 32'h0, 1'b0, 2);
        do_txn(0, 4'b0011, 16'h805B, 32'hBBDA_B777, 32'h0, 1'b0, 2);
        do_txn(0, 4'h0,    16'h805B, 32'h0, 32'hFFFF_B777, 1'b0, 3);
        do_txn(1, 4'b1100, 16'h805B, 32'h1234_5678, 32'h0, 1'b0, 2);
        do_txn(1, 4'h0,    16'h805B, 32'h0, 32'h1234_B777, 1'b0, 3);

        // Address window edges.
        do_txn(1, 4'hF, 16'h0040, 32'hDEAD_BEEF, 32'h0, 1'b1, 2);
        do_txn(1, 4'h0, 16'h0040, 32'h0, 32'h0, 1'b1, 2);
        do_txn(0, 4'hF, 16'h7FFF, 32'h0BAD_0BAD, 32'h0, 1'b1, 2);
        do_txn(0, 4'hF, 16'hFFFF, 32'hA5A5_5A5A, 32'h0, 1'b0, 2);
        do_txn(1, 4'h0, 16'hFFFF, 32'h0, 32'hA5A5_5A5A, 1'b0, 3);

        // Contention from the first IDLE after reset alternates 01,10,01,10.
        pulse_reset("rst_idle");
        @(negedge clk);
        bus.req   = 2'b11;
        bus.we    = 8'hFF;
        bus.addr  = {16'h8020, 16'h8010};
        bus.wdata = {32'h2222_2222, 32'h1111_1111};
        for (int k = 0; k < 4; k++) begin
            e.onehot = (k % 2 == 0) ? 2'b01 : 2'b10;
            e.rdata  = 32'h0;
            e.err    = 1'b0;
            e.t0     = -1;
            e.lat    = 0;
            gq.push_back(e);
            aq.push_back(e);
        end
        n = 0;
        budget = 0;
        while (n < 4 && budget < 60) begin
            @(negedge clk);
            budget++;
            if (bus.gnt != 2'b00) n++;
        end
        chk("contention_grants", 64'(n), 64'd4);
        clear_bus();
        wait_idle();
        chk("contention_acks_left", 64'(aq.size()), 64'd0);
        do_txn(0, 4'h0, 16'h8010, 32'h0, 32'h1111_1111, 1'b0, 3);
        do_txn(1, 4'h0, 16'h8020, 32'h0, 32'h2222_2222, 1'b0, 3);

        // Reset during WAIT drops the read without an ack.
        wait_idle();
        drive(0, 4'h0, 16'h8000, 32'h0);
        e.onehot = 2'b01;
        e.rdata  = 32'h0;
        e.err    = 1'b0;
        e.t0     = cyc;
        e.lat    = 1;
        gq.push_back(e);
        wait_bit("mid_gnt_seen", 0, 1'b0);
        clear_bus();
        @(negedge clk);
        chk("mid_read_busy", 64'(bus.busy), 64'd1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("mid_read");
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        do_txn(0, 4'h0, 16'h8000, 32'h0, 32'hFFFF_FFFF, 1'b0, 3);

        repeat (3) @(negedge clk);
        chk("gnt_queue_left", 64'(gq.size()), 64'd0);
        chk("ack_queue_left", 64'(aq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
